// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: read-domain consumer of the GP async FIFO.
// Pops WIDTH-bit words from a first-word-fall-through read port and packs RATIO
// of them (first popped in the low slot) into one flit on a valid/ready output.
// Optional build macro FIFO_RD_PACKER_TIMEOUT_EN adds an idle-timeout auto-flush;
// define NO_ASSERTIONS to drop the embedded property checks.
module fifo_rd_packer #(
  parameter int WIDTH   = 8,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk_rd,
  input  logic                   arst_rd,
  input  logic                   rd_empty_i,
  input  logic [WIDTH-1:0]       rd_data_i,
  output logic                   rd_en_o,
  input  logic                   flush_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [WIDTH*RATIO-1:0] out_data_o,
  output logic [$clog2(RATIO):0] out_cnt_o
);

  localparam int CW = $clog2(RATIO) + 1;
  localparam int FW = WIDTH * RATIO;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [FW-1:0] acc_r;
  logic [FW-1:0] acc_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          pop_s;
  logic          timeout_s;

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT) + 1;

  logic [IW-1:0] idle_r;
  logic [IW-1:0] idle_nxt_s;

  // Partial flit has sat idle long enough to be pushed out on its own.
  always_comb begin
    timeout_s = 1'b0;
    if ((cnt_r != {CW{1'b0}}) && (idle_r == IW'(TIMEOUT - 1))) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Idle counter advances only while a partial flit waits in FILL without pops.
  always_comb begin
    idle_nxt_s = {IW{1'b0}};
    if ((state_r == FILL) && (state_nxt_s == FILL) && (cnt_r != {CW{1'b0}}) && !pop_s) begin
      idle_nxt_s = idle_r + {{(IW-1){1'b0}}, 1'b1};
    end else begin
      idle_nxt_s = {IW{1'b0}};
    end
  end

  // Idle counter register.
  always_ff @(posedge clk_rd) begin
    if (arst_rd) begin
      idle_r <= {IW{1'b0}};
    end else begin
      idle_r <= idle_nxt_s;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state, pop strobe and accumulator update for the FILL/SEND packer.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    cnt_nxt_s   = cnt_r;
    pop_s       = 1'b0;
    case (state_r)
      FILL: begin
        pop_s = !rd_empty_i && !arst_rd;
        if (pop_s) begin
          for (int k = 0; k < RATIO; k++) begin
            if (cnt_r == CW'(k)) begin
              acc_nxt_s[k*WIDTH +: WIDTH] = rd_data_i;
            end else begin
              acc_nxt_s[k*WIDTH +: WIDTH] = acc_r[k*WIDTH +: WIDTH];
            end
          end
          cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
          cnt_nxt_s = cnt_r;
        end
        // A same-cycle pop is folded into a flushed flit.
        if (pop_s && (cnt_r == CW'(RATIO - 1))) begin
          state_nxt_s = SEND;
        end else if (flush_i && ((cnt_r != {CW{1'b0}}) || pop_s)) begin
          state_nxt_s = SEND;
        end else if (timeout_s && !pop_s) begin
          state_nxt_s = SEND;
        end else begin
          state_nxt_s = FILL;
        end
      end
      SEND: begin
        // Pops only alongside the handshake, so a stalled sink back-pressures the FIFO.
        pop_s = !rd_empty_i && out_ready_i && !arst_rd;
        if (out_ready_i) begin
          state_nxt_s = FILL;
          if (pop_s) begin
            acc_nxt_s = {{(FW-WIDTH){1'b0}}, rd_data_i};
            cnt_nxt_s = CW'(1);
          end else begin
            acc_nxt_s = {FW{1'b0}};
            cnt_nxt_s = {CW{1'b0}};
          end
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: begin
        state_nxt_s = FILL;
        acc_nxt_s   = {FW{1'b0}};
        cnt_nxt_s   = {CW{1'b0}};
      end
    endcase
  end

  // State, accumulator and word-count registers; reset discards any partial flit.
  always_ff @(posedge clk_rd) begin
    if (arst_rd) begin
      state_r <= FILL;
      acc_r   <= {FW{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign rd_en_o     = pop_s;
  assign out_valid_o = (state_r == SEND);
  assign out_data_o  = acc_r;
  assign out_cnt_o   = cnt_r;

`ifndef NO_ASSERTIONS
  localparam bit CFG_OK = (RATIO >= 2) && ((RATIO & (RATIO - 1)) == 0) && (TIMEOUT >= 1);

  a_cfg:          assert property (@(posedge clk_rd) CFG_OK);
  a_no_pop_empty: assert property (@(posedge clk_rd) rd_empty_i |-> !rd_en_o);
  a_cnt_max:      assert property (@(posedge clk_rd) cnt_r <= CW'(RATIO));
  a_send_hold:    assert property (@(posedge clk_rd) disable iff (arst_rd)
                    (out_valid_o && !out_ready_i) |=> (out_valid_o && $stable(out_data_o)));
`endif

endmodule
